jpeg_stuffer: RTL and testbench
===============================

JPEG_STUFFER -- requirements
Module: jpeg_stuffer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving the input word FIFO depth in 32-bit words; it SHALL be a power of two and at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din, input, 32 bits: entropy-coded word from the encoder stage; byte [31:24] is first in the stream.
REQ-005 SHALL have port din_valid, input, 1 bit: din is valid this cycle; there is no ready back to the encoder.
REQ-006 SHALL have port eoi, input, 1 bit: single-cycle request to append the end-of-image marker FF D9.
REQ-007 SHALL have port dout, output, 8 bits: JPEG stream byte.
REQ-008 SHALL have port dout_valid, output, 1 bit: dout holds a valid byte.
REQ-009 SHALL have port dout_ready, input, 1 bit: the sink accepts dout; a byte transfers on an edge where dout_valid and dout_ready are both high.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag showing that an input word was dropped.
REQ-011 SHALL have port busy, output, 1 bit: data or an EOI request is still in flight.

Function
REQ-012 SHALL write din into the FIFO on each edge with din_valid high, unless the FIFO is full and no pop happens on the same edge.
REQ-013 SHALL accept a push into a full FIFO when a pop occurs on the same edge.
REQ-014 SHALL drop the word and set overflow when a word arrives while the FIFO is full and no pop occurs; overflow SHALL stay high until reset.
REQ-015 SHALL implement the FSM states IDLE, DATA, STUFF, EOI_FF and EOI_D9.
REQ-016 In IDLE with the FIFO non-empty, SHALL pop one word into a 32-bit shift register, set the byte index to 0 and go to DATA.
REQ-017 The output slot SHALL be free when dout_valid is low or dout_ready is high.
REQ-018 In DATA with the slot free, SHALL load dout with the current byte in MSB-first order, assert dout_valid and advance the byte index.
REQ-019 Stuffing: when the byte emitted in DATA equals 0xFF, SHALL go to STUFF; in STUFF with the slot free, SHALL emit 0x00.
REQ-020 From STUFF, SHALL return to DATA if bytes remain in the word, or go to the word-end decision otherwise.
REQ-021 Word end (after byte 3 and any stuff byte): if the FIFO is non-empty, SHALL pop the next word and go straight to DATA with no idle cycle.
REQ-022 Word end with the FIFO empty: SHALL go to EOI_FF if EOI is pending, otherwise to IDLE.
REQ-023 SHALL latch eoi into a pending flag; a further eoi while the flag is set SHALL be ignored.
REQ-024 When eoi and din_valid are high on the same edge, SHALL emit that word before the marker.
REQ-025 From IDLE, SHALL go to EOI_FF only when the FIFO is empty and EOI is pending.
REQ-026 SHALL emit 0xFF in EOI_FF and then 0xD9 in EOI_D9, each only when the slot is free.
REQ-027 SHALL not stuff the EOI marker bytes.
REQ-028 After emitting 0xD9, SHALL clear the pending flag and return to IDLE.
REQ-029 While dout_valid is high and dout_ready is low, SHALL hold dout and dout_valid stable, and the FSM SHALL not advance.
REQ-030 Latency: with the FIFO empty, FSM in IDLE and dout_ready high, a word written on edge k SHALL show its first byte with dout_valid high after edge k+2.
REQ-031 Throughput: SHALL produce one output byte per cycle while dout_ready is high and data is available, with no gaps between words.
REQ-032 SHALL clear dout_valid after a transfer edge when no new byte is loaded on that edge.
REQ-033 busy SHALL equal: FIFO non-empty OR state not IDLE OR EOI pending OR dout_valid.

Reset
REQ-034 While nrst is low, SHALL hold: dout=0x00, dout_valid=0, overflow=0, busy=0, FIFO empty, state IDLE, EOI pending cleared.
REQ-035 Reset asserted mid-word or mid-marker SHALL abort the operation immediately, discarding the partial word and all FIFO contents.
REQ-036 After nrst rises, the first write SHALL be accepted on the first rising edge.

Verification
REQ-037 Word 0x12345678 with dout_ready high -> bytes 12, 34, 56, 78 on consecutive cycles, first one valid two edges after the write.
REQ-038 Word 0xFF00FFAB -> bytes FF, 00, 00, FF, 00, AB.
REQ-039 dout_ready low for 3 cycles after byte 34 of 0x12345678 -> dout held at 0x56 with dout_valid high, then 56, 78, no loss or duplicate.
REQ-040 Words 0xAABBCCDD and 0x11223344, then eoi -> AA BB CC DD 11 22 33 44 FF D9, then busy falls to 0.
REQ-041 FIFO_DEPTH=8, dout_ready low, 10 words pushed -> overflow=1 on the 10th push; 9 words (8 in FIFO plus 1 in the shift register) emitted after dout_ready rises; 10th word absent.
REQ-042 nrst pulsed low during the second byte of a word -> dout_valid=0 and busy=0 at once; next word emitted in full from its byte [31:24].

Source files
------------

// File: rtl/jpeg_stuffer.sv
// rtl/jpeg_stuffer.sv - JPEG byte stuffer: 32-bit word FIFO to byte stream with 0xFF stuffing and EOI marker
module jpeg_stuffer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] din,
    input  logic        din_valid,
    input  logic        eoi,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_STUFF  = 3'd2;
    localparam logic [2:0] S_EOI_FF = 3'd3;
    localparam logic [2:0] S_EOI_D9 = 3'd4;

    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, rptr_q;
    logic        fifo_empty, fifo_full;
    logic        push, pop;
    logic [31:0] fifo_rdata;

    logic [2:0]  state_q, state_d;
    logic [31:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d, pend_clr;
    logic [7:0]  dout_q, out_byte;
    logic        dout_valid_q, load;
    logic        overflow_q, overflow_d;
    logic        slot_free, word_end;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_rdata = mem_q[rptr_q[AW-1:0]];
    assign push       = din_valid && (!fifo_full || pop);
    assign overflow_d = overflow_q || (din_valid && fifo_full && !pop);

    assign slot_free  = !dout_valid_q || dout_ready;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        load     = 1'b0;
        out_byte = 8'h00;
        pend_clr = 1'b0;
        word_end = 1'b0;
        case (state_q)
            S_IDLE: word_end = 1'b1;
            S_DATA: begin
                if (slot_free) begin
                    load     = 1'b1;
                    out_byte = sh_q[31:24];
                    sh_d     = {sh_q[23:0], 8'h00};
                    cnt_d    = cnt_q + 3'd1;
                    if (sh_q[31:24] == 8'hFF) begin
                        state_d = S_STUFF;
                    end else if (cnt_q == 3'd3) begin
                        word_end = 1'b1;
                    end
                end
            end
            S_STUFF: begin
                if (slot_free) begin
                    load     = 1'b1;
                    out_byte = 8'h00;
                    if (cnt_q == 3'd4) begin
                        word_end = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_EOI_FF: begin
                if (slot_free) begin
                    load     = 1'b1;
                    out_byte = 8'hFF;
                    state_d  = S_EOI_D9;
                end
            end
            S_EOI_D9: begin
                if (slot_free) begin
                    load     = 1'b1;
                    out_byte = 8'hD9;
                    pend_clr = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Shared by IDLE and end-of-word: chain straight into the next word when one is queued.
        if (word_end) begin
            if (!fifo_empty) begin
                pop     = 1'b1;
                sh_d    = fifo_rdata;
                cnt_d   = 3'd0;
                state_d = S_DATA;
            end else if (pend_q) begin
                state_d = S_EOI_FF;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    assign pend_d = pend_clr ? 1'b0 : (pend_q || eoi);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            state_q      <= S_IDLE;
            sh_q         <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            state_q    <= state_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            if (slot_free) begin
                dout_valid_q <= load;
                if (load) begin
                    dout_q <= out_byte;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign busy       = !fifo_empty || (state_q != S_IDLE) || pend_q || dout_valid_q;

endmodule

// File: tb/tb_jpeg_stuffer.sv
// tb/tb_jpeg_stuffer.sv - scoreboard bench for jpeg_stuffer with randomized words and sink backpressure
module tb_jpeg_stuffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        eoi = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int ready_mode = 1;
    int words_pushed = 0;
    int words_done = 0;

    logic [7:0] exp_b[$];
    bit         exp_last[$];
    bit         held_v = 1'b0;
    logic [7:0] held_b = 8'h00;

    jpeg_stuffer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .din(din), .din_valid(din_valid), .eoi(eoi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // 0: sink stalled, 1: always ready, 2: ready 3 cycles in 4 at random
    always @(posedge clk) begin
        case (ready_mode)
            0:       dout_ready <= 1'b0;
            1:       dout_ready <= 1'b1;
            default: dout_ready <= ($urandom_range(3) != 0);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Stream rules: bytes MSB first, every data 0xFF followed by 0x00.
    function automatic void model_word(input logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[31 - 8*i -: 8];
            exp_b.push_back(b);
            exp_last.push_back((i == 3) && (b != 8'hFF));
            if (b == 8'hFF) begin
                exp_b.push_back(8'h00);
                exp_last.push_back(i == 3);
            end
        end
    endfunction

    function automatic void model_eoi();
        exp_b.push_back(8'hFF);
        exp_last.push_back(1'b0);
        exp_b.push_back(8'hD9);
        exp_last.push_back(1'b0);
    endfunction

    always @(negedge clk) begin
        if (!nrst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if (!(dout_valid === 1'b1 && dout === held_b)) begin
                    failures++;
                    $display("FAIL hold_stable actual=%0b/%0h required=1/%0h", dout_valid, dout, held_b);
                end
            end
            held_v = dout_valid && !dout_ready;
            held_b = dout;
            if (dout_valid === 1'b1 && dout_ready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", dout);
                end else begin
                    if (dout !== exp_b[0]) begin
                        failures++;
                        $display("FAIL stream_byte actual=%0h required=%0h", dout, exp_b[0]);
                    end
                    if (exp_last[0]) words_done++;
                    void'(exp_b.pop_front());
                    void'(exp_last.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w, input bit with_eoi, input bit kept);
        din = w;
        din_valid = 1'b1;
        eoi = with_eoi;
        if (kept) begin
            model_word(w);
            words_pushed++;
        end
        if (with_eoi) model_eoi();
        tick();
        din_valid = 1'b0;
        eoi = 1'b0;
    endtask

    task automatic send_eoi();
        eoi = 1'b1;
        model_eoi();
        tick();
        eoi = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_b.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending_bytes", exp_b.size(), 0);
    endtask

    task automatic wait_byte(input logic [7:0] b, input string name);
        int n = 0;
        while (!(dout_valid && dout == b) && n < 20) begin
            tick();
            n++;
        end
        check(name, dout_valid && dout == b, 1);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[8*i +: 8] = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(255));
        end
        return w;
    endfunction

    initial begin
        int guard;
        tick();
        tick();
        check("reset_dout", dout, 8'h00);
        check("reset_dout_valid", dout_valid, 0);
        check("reset_overflow", overflow, 0);
        check("reset_busy", busy, 0);
        nrst = 1'b1;

        // latency and back-to-back bytes
        push_word(32'h12345678, 1'b0, 1'b1);
        check("lat_edge_k", dout_valid, 0);
        tick();
        check("lat_edge_k1", dout_valid, 0);
        tick();
        check("lat_edge_k2", {dout_valid, dout}, {1'b1, 8'h12});
        tick();
        check("seq_byte1", {dout_valid, dout}, {1'b1, 8'h34});
        tick();
        check("seq_byte2", {dout_valid, dout}, {1'b1, 8'h56});
        tick();
        check("seq_byte3", {dout_valid, dout}, {1'b1, 8'h78});
        tick();
        check("valid_clears", dout_valid, 0);
        wait_idle(50);

        push_word(32'hFF00FFAB, 1'b0, 1'b1);
        wait_idle(50);

        // sink stall after byte 0x34
        push_word(32'h12345678, 1'b0, 1'b1);
        wait_byte(8'h34, "stall_reach_34");
        ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_56", {dout_valid, dout}, {1'b1, 8'h56});
            if (i == 1) ready_mode = 1;
        end
        wait_idle(50);

        push_word(32'hAABBCCDD, 1'b0, 1'b1);
        push_word(32'h11223344, 1'b0, 1'b1);
        send_eoi();
        wait_idle(100);
        check("eoi_busy_low", busy, 0);

        push_word(32'hCAFEFF01, 1'b1, 1'b1);
        wait_idle(100);

        // overflow: 8 in FIFO, 1 in shift register, 10th dropped
        ready_mode = 0;
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            push_word(32'h01010101 * (i + 1), 1'b0, i < 9);
            if (i == 8) check("ovf_before_10th", overflow, 0);
            if (i == 9) check("ovf_on_10th", overflow, 1);
        end
        ready_mode = 1;
        wait_idle(200);
        check("ovf_sticky", overflow, 1);

        // reset during the second byte of a word
        push_word(32'h01020304, 1'b0, 1'b1);
        wait_byte(8'h02, "rst_reach_02");
        nrst = 1'b0;
        #1;
        check("rst_mid_valid", dout_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_overflow", overflow, 0);
        exp_b.delete();
        exp_last.delete();
        words_pushed = words_done;
        tick();
        nrst = 1'b1;
        push_word(32'h0A0B0C0D, 1'b0, 1'b1);
        wait_idle(50);

        // randomized words with random backpressure
        ready_mode = 2;
        for (int w = 0; w < 300; w++) begin
            guard = 0;
            while ((words_pushed - words_done) >= DEPTH && guard < 200) begin
                tick();
                guard++;
            end
            check("rand_inflight_bound", guard < 200, 1);
            if ((w % 37) == 36) begin
                push_word(rand_word(), ($urandom_range(1) == 0), 1'b1);
                if (exp_b.size() == 0 || exp_b[$] != 8'hD9) send_eoi();
                wait_idle(400);
            end else begin
                push_word(rand_word(), 1'b0, 1'b1);
                repeat ($urandom_range(2)) tick();
            end
        end
        ready_mode = 1;
        wait_idle(2000);
        check("final_overflow", overflow, 0);
        check("final_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
